// File: rtl/sdram_port_arbiter_if.sv
// sdram_port_arbiter_if: requester-side and SDRAM-controller-side signals of the port arbiter
interface sdram_port_arbiter_if #(
  parameter int ADDR_W = 24,
  parameter int DATA_W = 8
);
  logic [2:0] req, we, ack, grant;
  logic [ADDR_W-1:0] addr0, addr1, addr2, sd_addr;
  logic [DATA_W-1:0] din0, din1, din2, dout, sd_din, sd_dout;
  logic busy, timeout_err, sd_req, sd_we, sd_ready;
  modport slave (
    input  req, addr0, addr1, addr2, we, din0, din1, din2, sd_ready, sd_dout,
    output ack, dout, grant, busy, timeout_err, sd_req, sd_addr, sd_we, sd_din
  );
  modport master (
    output req, addr0, addr1, addr2, we, din0, din1, din2, sd_ready, sd_dout,
    input  ack, dout, grant, busy, timeout_err, sd_req, sd_addr, sd_we, sd_din
  );
endinterface

// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter: shares one SDRAM command port between CPU (fixed priority), disk and ioctl
// (round-robin), one transaction at a time, with a watchdog that aborts a stalled controller.
module sdram_port_arbiter #(
  parameter int ADDR_W  = 24,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 255
) (
  input logic clk_sys,
  input logic reset_n,
  sdram_port_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  state_t state, state_nxt;
  logic rr;
  logic [15:0] cnt;
  logic [2:0] win;
  logic tmo;
  always_ff @(posedge clk_sys or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_nxt;
  // rr=0 prefers disk, rr=1 prefers ioctl; a lone disk/ioctl request wins on its own
  always_comb begin
    win = bus.req[0] ? 3'b001 :
          (bus.req[1] && bus.req[2]) ? (rr ? 3'b100 : 3'b010) :
          {bus.req[2], bus.req[1], 1'b0};
    tmo = cnt == 16'(TIMEOUT - 1);
    state_nxt = state == IDLE  ? (win != 3'b000 ? ISSUE : IDLE) :
                state == ISSUE ? WAIT :
                state == WAIT  ? ((bus.sd_ready || tmo) ? DONE : WAIT) :
                IDLE;
    bus.ack = state == DONE ? bus.grant : 3'b000;
    bus.sd_req = state == ISSUE;
    bus.busy = state != IDLE;
  end
  always_ff @(posedge clk_sys or negedge reset_n)
    if (!reset_n) begin
      bus.grant <= 3'b000;
      bus.sd_addr <= {ADDR_W{1'b0}};
      bus.sd_we <= 1'b0;
      bus.sd_din <= {DATA_W{1'b0}};
      bus.dout <= {DATA_W{1'b0}};
      bus.timeout_err <= 1'b0;
      rr <= 1'b0;
      cnt <= 16'd0;
    end else begin
      if (state == IDLE && win != 3'b000) begin
        bus.grant <= win;
        bus.sd_addr <= win[0] ? bus.addr0 : win[1] ? bus.addr1 : bus.addr2;
        bus.sd_we <= |(win & bus.we);
        bus.sd_din <= win[0] ? bus.din0 : win[1] ? bus.din1 : bus.din2;
      end
      // sd_ready is checked before the watchdog so a last-cycle completion is not flagged
      if (state == WAIT) begin
        if (bus.sd_ready) bus.dout <= bus.sd_dout;
        else if (tmo) begin
          bus.dout <= {DATA_W{1'b1}};
          bus.timeout_err <= 1'b1;
        end else cnt <= cnt + 16'd1;
      end
      if (state == DONE) begin
        bus.grant <= 3'b000;
        cnt <= 16'd0;
        rr <= bus.grant[1] | (rr & ~bus.grant[2]);
      end
    end
endmodule

// File: tb/tb_sdram_port_arbiter.sv
// tb_sdram_port_arbiter: directed test-plan scenarios plus randomized traffic, checked every
// cycle against a transaction-timeline model of the arbiter.
module tb_sdram_port_arbiter;
  localparam int TMO = 8;
  logic clk_sys = 0;
  logic reset_n = 1;
  bit run = 0;
  int vectors = 0, miscompares = 0;
  int lat_mode = 2;
  logic [7:0] rd_data = 8'h00;
  int pend = -1;
  sdram_port_arbiter_if #(.ADDR_W(24), .DATA_W(8)) bus ();
  sdram_port_arbiter #(.ADDR_W(24), .DATA_W(8), .TIMEOUT(TMO)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .bus(bus)
  );
  always #5 clk_sys = ~clk_sys;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a transaction granted at edge g issues in cycle g, may complete on any sampled
  // sd_ready at edges g+2..g+TMO+1 (else times out at g+TMO+1), acks in the completion
  // cycle and frees the port one edge later.
  int cyc = 0, g = 0, done_at = 0, owner = 0, pref = 1;
  bit active = 0;
  logic [2:0] e_ack = 0, e_grant = 0;
  logic e_busy = 0, e_sdreq = 0, e_err = 0, e_we = 0;
  logic [23:0] e_addr = 0;
  logic [7:0] e_din = 0, e_dout = 0;
  always @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      active = 0; pref = 1; e_grant = 0; e_err = 0; e_we = 0;
      e_addr = 0; e_din = 0; e_dout = 0;
    end else begin
      cyc++;
      if (active && done_at == 0 && cyc >= g + 2) begin
        if (bus.sd_ready) begin done_at = cyc; e_dout = bus.sd_dout; end
        else if (cyc == g + TMO + 1) begin done_at = cyc; e_dout = 8'hFF; e_err = 1; end
      end else if (active && done_at != 0 && cyc == done_at + 1) begin
        active = 0; e_grant = 0;
        pref = owner == 1 ? 2 : owner == 2 ? 1 : pref;
      end else if (!active && bus.req != 0) begin
        owner = bus.req[0] ? 0 : (bus.req[1] && bus.req[2]) ? pref : bus.req[1] ? 1 : 2;
        active = 1; g = cyc; done_at = 0;
        e_grant = 3'(1 << owner);
        e_we = bus.we[owner];
        e_addr = owner == 0 ? bus.addr0 : owner == 1 ? bus.addr1 : bus.addr2;
        e_din = owner == 0 ? bus.din0 : owner == 1 ? bus.din1 : bus.din2;
      end
    end
    e_busy = active;
    e_sdreq = active && cyc == g;
    e_ack = (active && done_at != 0 && done_at == cyc) ? e_grant : 3'b000;
  end

  always @(negedge clk_sys) if (run) begin
    chk("ack", 32'(bus.ack), 32'(e_ack));
    chk("grant", 32'(bus.grant), 32'(e_grant));
    chk("busy", 32'(bus.busy), 32'(e_busy));
    chk("sd_req", 32'(bus.sd_req), 32'(e_sdreq));
    chk("timeout_err", 32'(bus.timeout_err), 32'(e_err));
    chk("dout", 32'(bus.dout), 32'(e_dout));
    chk("sd_addr", 32'(bus.sd_addr), 32'(e_addr));
    chk("sd_we", 32'(bus.sd_we), 32'(e_we));
    chk("sd_din", 32'(bus.sd_din), 32'(e_din));
  end

  // Controller: answers each sd_req after lat_mode WAIT cycles (-1 random with stray pulses,
  // 99 never)
  always @(negedge clk_sys) begin
    bus.sd_ready = 0;
    bus.sd_dout = lat_mode >= 0 ? rd_data : 8'($urandom);
    if (!reset_n) pend = -1;
    else if (pend == 0) begin bus.sd_ready = 1; pend = -1; end
    else if (pend > 0) pend--;
    else if (lat_mode < 0 && $urandom_range(0, 29) == 0) bus.sd_ready = 1;
    if (reset_n && bus.sd_req)
      pend = lat_mode < 0 ? int'($urandom_range(0, 10)) : lat_mode == 99 ? -1 : lat_mode;
  end

  task automatic wait_for(input bit on_ack, input string name, output int n);
    n = 0;
    do begin
      @(negedge clk_sys);
      n++;
    end while ((on_ack ? bus.ack : {2'b00, bus.sd_req}) == 3'b000 && n < 40);
    if ((on_ack ? bus.ack : {2'b00, bus.sd_req}) == 3'b000) begin
      vectors++;
      miscompares++;
      $display("FAIL %s: no response within %0d cycles", name, n);
    end
  endtask

  initial begin
    int n;
    bit [2:0] drop_nxt = 0;
    bit [2:0] seq [4] = '{3'b010, 3'b100, 3'b010, 3'b100};
    bus.req = 0; bus.we = 0;
    bus.addr0 = 0; bus.addr1 = 0; bus.addr2 = 0;
    bus.din0 = 0; bus.din1 = 0; bus.din2 = 0;
    #1 reset_n = 0;
    repeat (2) @(negedge clk_sys);
    run = 1;
    chk("rst_grant", 32'(bus.grant), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_err", 32'(bus.timeout_err), 0);
    chk("rst_dout", 32'(bus.dout), 0);
    chk("rst_sd_addr", 32'(bus.sd_addr), 0);
    @(negedge clk_sys); reset_n = 1;
    // CPU read answered in the second WAIT cycle
    @(negedge clk_sys);
    bus.req = 3'b001; bus.addr0 = 24'h000300; lat_mode = 1; rd_data = 8'hA9;
    wait_for(0, "cpu_issue", n);
    chk("cpu_issue_lat", n, 1);
    chk("cpu_sd_addr", 32'(bus.sd_addr), 32'h000300);
    chk("cpu_sd_we", 32'(bus.sd_we), 0);
    chk("cpu_grant", 32'(bus.grant), 1);
    wait_for(1, "cpu_ack", n);
    chk("cpu_ack_lat", n, 3);
    chk("cpu_ack", 32'(bus.ack), 1);
    chk("cpu_dout", 32'(bus.dout), 32'hA9);
    bus.req = 0;
    @(negedge clk_sys);
    chk("cpu_grant_clr", 32'(bus.grant), 0);
    // disk and ioctl held continuously alternate starting with disk
    lat_mode = 2; rd_data = 8'h11;
    bus.req = 3'b110; bus.addr1 = 24'h00AA00; bus.addr2 = 24'h00BB00;
    for (int k = 0; k < 4; k++) begin
      wait_for(1, "rr_ack", n);
      chk("rr_ack", 32'(bus.ack), 32'(seq[k]));
    end
    bus.req = 0;
    // CPU and ioctl arrive while disk waits: disk, then CPU, then ioctl
    @(negedge clk_sys);
    lat_mode = 3; bus.req = 3'b010;
    wait_for(0, "prio_issue", n);
    @(negedge clk_sys);
    bus.req = 3'b111;
    wait_for(1, "prio_ack0", n);
    chk("prio_ack0", 32'(bus.ack), 32'b010);
    bus.req = 3'b101;
    wait_for(1, "prio_ack1", n);
    chk("prio_ack1", 32'(bus.ack), 32'b001);
    bus.req = 3'b100;
    wait_for(1, "prio_ack2", n);
    chk("prio_ack2", 32'(bus.ack), 32'b100);
    bus.req = 0;
    // ioctl write
    @(negedge clk_sys);
    lat_mode = 0; rd_data = 8'h77;
    bus.req = 3'b100; bus.we = 3'b100; bus.din2 = 8'h5C; bus.addr2 = 24'h012345;
    wait_for(0, "wr_issue", n);
    chk("wr_sd_we", 32'(bus.sd_we), 1);
    chk("wr_sd_din", 32'(bus.sd_din), 32'h5C);
    chk("wr_sd_addr", 32'(bus.sd_addr), 32'h012345);
    wait_for(1, "wr_ack", n);
    chk("wr_ack_lat", n, 2);
    chk("wr_ack", 32'(bus.ack), 32'b100);
    bus.req = 0; bus.we = 0;
    // watchdog: no sd_ready at all
    @(negedge clk_sys);
    lat_mode = 99; bus.req = 3'b001; bus.addr0 = 24'h000400;
    wait_for(0, "to_issue", n);
    wait_for(1, "to_ack", n);
    chk("to_ack_lat", n, TMO + 1);
    chk("to_dout", 32'(bus.dout), 32'hFF);
    chk("to_err", 32'(bus.timeout_err), 1);
    bus.req = 0;
    @(negedge clk_sys);
    lat_mode = 0; rd_data = 8'h3C; bus.req = 3'b001;
    wait_for(1, "to_after_ack", n);
    chk("to_after_dout", 32'(bus.dout), 32'h3C);
    chk("to_err_sticky", 32'(bus.timeout_err), 1);
    bus.req = 0;
    // reset in the middle of WAIT
    @(negedge clk_sys);
    lat_mode = 99; bus.req = 3'b001;
    wait_for(0, "mid_issue", n);
    repeat (2) @(negedge clk_sys);
    #2 reset_n = 0;
    #1;
    chk("mid_busy", 32'(bus.busy), 0);
    chk("mid_grant", 32'(bus.grant), 0);
    chk("mid_ack", 32'(bus.ack), 0);
    chk("mid_err", 32'(bus.timeout_err), 0);
    chk("mid_sd_addr", 32'(bus.sd_addr), 0);
    bus.req = 0;
    repeat (2) @(negedge clk_sys);
    reset_n = 1;
    @(negedge clk_sys);
    lat_mode = 0; rd_data = 8'h5A; bus.req = 3'b001;
    wait_for(1, "post_ack", n);
    chk("post_ack", 32'(bus.ack), 1);
    chk("post_dout", 32'(bus.dout), 32'h5A);
    chk("post_err", 32'(bus.timeout_err), 0);
    bus.req = 0;
    // randomized traffic with random latency, stray sd_ready pulses and rare resets
    lat_mode = -1;
    repeat (4000) begin
      @(negedge clk_sys);
      if ($urandom_range(0, 799) == 0) begin
        #2 reset_n = 0;
        @(negedge clk_sys);
        reset_n = 1; bus.req = 0; drop_nxt = 0;
      end else
        for (int i = 0; i < 3; i++) begin
          if (drop_nxt[i]) begin
            bus.req[i] = 0; drop_nxt[i] = 0;
          end else if (bus.req[i] && bus.ack[i]) begin
            case ($urandom_range(0, 3))
              0, 1: bus.req[i] = 0;
              2: drop_nxt[i] = 1;
              default: ;
            endcase
          end else if (!bus.req[i] && $urandom_range(0, 3) == 0) begin
            bus.req[i] = 1;
            bus.we[i] = 1'($urandom);
            if (i == 0) begin bus.addr0 = 24'($urandom); bus.din0 = 8'($urandom); end
            if (i == 1) begin bus.addr1 = 24'($urandom); bus.din1 = 8'($urandom); end
            if (i == 2) begin bus.addr2 = 24'($urandom); bus.din2 = 8'($urandom); end
          end
        end
    end
    bus.req = 0;
    repeat (30) @(negedge clk_sys);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/sdram_port_arbiter.md
Name: sdram_port_arbiter

Overview:
- Shares the single SDRAM controller command port between three requesters in the Apple IIe core: CPU/video bus, disk track buffer, and ioctl ROM/disk download.
- Sits between the requesters and the SDRAM controller inside the core, in the clk_sys domain (14 MHz).
- CPU has fixed top priority. Disk and ioctl share round-robin.
- Runs one transaction at a time, has a watchdog, and reports a sticky error if the controller fails to respond.

Parameters:
ADDR_W, 24, SDRAM byte address width
DATA_W, 8, data width per transaction
TIMEOUT, 255, clk_sys cycles to wait for sd_ready before aborting (legal range 2..65535)

Ports:
clk_sys  in  1  system clock (14 MHz)
reset_n  in  1  asynchronous active-low reset
req  in  3  level requests; bit0 CPU, bit1 disk, bit2 ioctl
addr0/addr1/addr2  in  ADDR_W each  per-requester address, stable while req high
we  in  3  per-requester write enable, stable while req high
din0/din1/din2  in  DATA_W each  per-requester write data
ack  out  3  one-cycle completion pulse, one-hot
dout  out  DATA_W  read data, valid from the ack cycle until the next ack
grant  out  3  one-hot owner of the current transaction; 0 when idle
busy  out  1  high whenever state is not IDLE
timeout_err  out  1  sticky watchdog flag
sd_req  out  1  one-cycle command strobe to the SDRAM controller
sd_addr  out  ADDR_W  registered command address
sd_we  out  1  registered write enable
sd_din  out  DATA_W  registered write data
sd_ready  in  1  one-cycle completion pulse from the controller
sd_dout  in  DATA_W  controller read data, valid with sd_ready

Behaviour:
- Reset (async on reset_n low, released synchronously by design):
  - State IDLE.
  - ack, grant, busy, sd_req, sd_we, timeout_err = 0.
  - sd_addr, sd_din, dout = 0.
  - Round-robin pointer rr = disk, meaning disk is preferred.
  - Watchdog counter = 0.
- State IDLE:
  - At each edge, if req is nonzero, pick the winner:
    - CPU if req[0].
    - Otherwise, if both req[1] and req[2], the one rr points to.
    - Otherwise the single requester.
  - Latch the winner's addr, we and din into sd_addr/sd_we/sd_din.
  - Set grant to the winner and go to ISSUE.
- State ISSUE:
  - sd_req = 1 for exactly this one cycle, then go to WAIT.
  - Latency: req first sampled high at edge N gives sd_req high during the cycle after edge N.
- State WAIT:
  - The watchdog counts each cycle.
  - On sd_ready: capture sd_dout into dout (write transactions capture it too) and go to DONE.
  - If the counter reaches TIMEOUT-1 without sd_ready: set timeout_err, load dout = all ones, go to DONE.
  - If sd_ready and the timeout land in the same cycle, sd_ready wins and no error is flagged.
- State DONE:
  - ack[grant] = 1 for one cycle.
  - If grant was disk, rr becomes ioctl; if grant was ioctl, rr becomes disk. A CPU grant leaves rr unchanged.
  - Clear grant and the counter, then go to IDLE.
- Requester rule: req must be low by the edge that ends the cycle after its ack. A registered drop on ack is enough. If req is still high in IDLE, it is a new transaction.
- A req that rises or falls while another transaction is in flight is sampled only in IDLE. There is no preemption.
- sd_ready outside WAIT is ignored.
- timeout_err clears only on reset.
- Minimum transaction: IDLE to ISSUE to WAIT to DONE, i.e. ack 3 cycles after the grant edge when sd_ready arrives in the first WAIT cycle. Back-to-back throughput is one transaction per 4 + controller-latency cycles.
- Reset mid-transaction: the transaction is abandoned with no ack, and all outputs return to reset values immediately. Requesters must reissue.
- The SDRAM controller must tolerate a dropped transaction.

Test Plan:
- CPU read: req=3'b001, addr0=24'h000300, sd_ready with sd_dout=8'hA9 in the second WAIT cycle -> sd_req high one cycle with sd_addr=24'h000300 and sd_we=0; ack=3'b001 one cycle later with dout=8'hA9; grant back to 0.
- Disk and ioctl held high continuously with 2-cycle controller latency -> grants alternate disk, ioctl, disk, ioctl starting with disk; no requester gets two consecutive acks.
- Priority: disk transaction in WAIT, then CPU and ioctl both raise req -> disk completes, then CPU is served, then ioctl.
- Write: req=3'b100, we[2]=1, din2=8'h5C, addr2=24'h012345 -> sd_we=1, sd_din=8'h5C, sd_addr=24'h012345; ack[2] after sd_ready.
- Timeout with TIMEOUT=8 and sd_ready never asserted -> ack pulse 8 WAIT cycles after ISSUE, dout=8'hFF, timeout_err=1 and still 1 after further successful transactions.
- reset_n low during WAIT -> outputs go to zero asynchronously with no ack; after release, a fresh CPU request completes normally with timeout_err=0.
